io_sequencer: RTL and testbench
===============================

Name: io_sequencer

Overview:
- Multi-cycle sequencer for the processor's IO instructions, driven by the decoder's IO_Enable / IO_Selection / Draw_Select outputs.
- Stalls the pipeline while an IO operation waits on a peripheral.
- Performs the handshakes with the switch bank (IN), keyboard (GETCH), 7-segment display (OUT) and video unit (DWPX/DWCH).
- Returns read data for register writeback.

Parameters:
DATA_WIDTH, 32, width of register operands and Read_Data
SW_WIDTH, 16, width of switch bank input
KEY_WIDTH, 8, width of keyboard scan code

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
IO_Enable  input  1  decoder: current instruction is IO
IO_Selection  input  2  0=OUT, 1=IN, 2=GETCH, 3=DRAW
Draw_Select  input  1  0=pixel (DWPX), 1=char (DWCH); valid when IO_Selection=3
Op_A  input  DATA_WIDTH  first source register value (OUT data / draw data)
Op_B  input  DATA_WIDTH  second source register value (draw coordinates)
Stall  output  1  freeze PC and pipeline registers
Read_Data  output  DATA_WIDTH  captured input value, zero-extended
Read_Valid  output  1  one-cycle pulse: Read_Data ready for writeback
Switch_Data  input  SW_WIDTH  switch bank, synchronized externally
Switch_Confirm  input  1  debounced confirm button, level
Key_Valid  input  1  keyboard FIFO non-empty
Key_Code  input  KEY_WIDTH  keyboard FIFO head
Key_Ack  output  1  pop keyboard FIFO
Disp_Data  output  DATA_WIDTH  display register
Disp_Load  output  1  one-cycle pulse after Disp_Data update
Vid_Req  output  1  draw request, held until accepted
Vid_Mode  output  1  latched Draw_Select
Vid_Data  output  DATA_WIDTH  latched Op_A
Vid_Arg  output  DATA_WIDTH  latched Op_B
Vid_Ready  input  1  video unit accepts request this cycle

Behaviour:
- FSM states: IDLE, WAIT_SW, WAIT_REL, WAIT_KEY, WAIT_VID, DONE.
- Reset (asserted at any time, including mid-operation):
  - state -> IDLE.
  - Read_Data, Disp_Data, Vid_Data, Vid_Arg -> 0.
  - Vid_Mode, Disp_Load, Read_Valid, Key_Ack, Vid_Req -> 0.
  - Any pending handshake is abandoned.
- Stall (combinational): 1 in WAIT_SW, WAIT_REL, WAIT_KEY, WAIT_VID; 1 in IDLE when IO_Enable=1 and IO_Selection≠0; 0 otherwise (including DONE).
- IDLE, IO_Enable=0: remain IDLE.
- IDLE, OUT (sel 0): Disp_Data <= Op_A; Disp_Load=1 next cycle only; stay IDLE; no stall.
- IDLE, IN (sel 1) -> WAIT_SW.
- IDLE, GETCH (sel 2) -> WAIT_KEY.
- IDLE, DRAW (sel 3) -> WAIT_VID; latch Vid_Mode<=Draw_Select, Vid_Data<=Op_A, Vid_Arg<=Op_B on the same edge.
- WAIT_SW: on Switch_Confirm=1, Read_Data <= zero-extended Switch_Data, then -> WAIT_REL.
- WAIT_REL: stay until Switch_Confirm=0, then -> DONE. Guarantees one press satisfies exactly one IN.
- WAIT_KEY:
  - Key_Ack = (state==WAIT_KEY && Key_Valid), combinational, exactly one cycle.
  - On that cycle, Read_Data <= zero-extended Key_Code, then -> DONE.
- WAIT_VID:
  - Vid_Req=1; Vid_Mode/Data/Arg held stable.
  - Transfer on Vid_Req && Vid_Ready; then -> DONE, Vid_Req=0 from DONE on.
- DONE:
  - Read_Valid=1 iff the completed operation was IN or GETCH (tracked by a registered op flag); 0 after DRAW.
  - Stall=0 so the instruction retires on this edge.
  - IO_Enable ignored; -> IDLE unconditionally.
- Latency, counted from the IDLE edge:
  - OUT: 0 stall cycles.
  - GETCH with Key_Valid already high: 2 stall cycles (IDLE, WAIT_KEY), then DONE.
  - DRAW with Vid_Ready high: 2 stall cycles.
  - IN: stall until confirm pressed and released, plus 1 cycle.
- Read_Data holds its last value until the next capture.
- Disp_Data holds until the next OUT.
- Back-to-back IO instructions: the second is decoded in the IDLE cycle after DONE; no operation is lost or duplicated.
- IO_Selection changes while not in IDLE are ignored.

Test Plan:
- Reset mid-WAIT_VID with Vid_Ready=0 -> next cycle state IDLE, Vid_Req=0, Stall=0, Vid_Data=0.
- OUT, Op_A=0x0000ABCD -> no Stall; Disp_Data=0x0000ABCD and Disp_Load=1 for exactly one cycle after the edge.
- GETCH with Key_Valid=0 for 5 cycles, then Key_Code=0x1C valid -> Stall high 6 cycles; Key_Ack exactly one cycle; Read_Valid one cycle later with Read_Data=0x0000001C.
- IN with Switch_Data=0x8001:
  - Confirm held 4 cycles, then released -> Read_Data=0x00008001; Read_Valid only after release; Stall covers the whole hold.
  - A following IN stalls until a new press.
- DWCH, Op_A=0x41, Op_B=0x00050003, Vid_Ready low 3 cycles -> Vid_Req high 4 cycles with Vid_Mode=1 and data stable; Read_Valid never asserted.
- GETCH immediately followed by OUT, Key_Valid high -> exactly one Key_Ack; Disp_Load pulses once, in the cycle after the OUT's IDLE edge.

Source files
------------

// File: rtl/io_sequencer_if.sv
// Decoder, peripheral and writeback signals of the IO sequencer.
// The master side (decoder/peripherals) drives requests and status; the slave side is the sequencer.
interface io_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SW_WIDTH   = 16,
    parameter int KEY_WIDTH  = 8
);
    logic                  IO_Enable;
    logic [1:0]            IO_Selection;
    logic                  Draw_Select;
    logic [DATA_WIDTH-1:0] Op_A;
    logic [DATA_WIDTH-1:0] Op_B;
    logic                  Stall;
    logic [DATA_WIDTH-1:0] Read_Data;
    logic                  Read_Valid;
    logic [SW_WIDTH-1:0]   Switch_Data;
    logic                  Switch_Confirm;
    logic                  Key_Valid;
    logic [KEY_WIDTH-1:0]  Key_Code;
    logic                  Key_Ack;
    logic [DATA_WIDTH-1:0] Disp_Data;
    logic                  Disp_Load;
    logic                  Vid_Req;
    logic                  Vid_Mode;
    logic [DATA_WIDTH-1:0] Vid_Data;
    logic [DATA_WIDTH-1:0] Vid_Arg;
    logic                  Vid_Ready;

    modport master (
        output IO_Enable, IO_Selection, Draw_Select, Op_A, Op_B,
        output Switch_Data, Switch_Confirm, Key_Valid, Key_Code, Vid_Ready,
        input  Stall, Read_Data, Read_Valid, Key_Ack, Disp_Data, Disp_Load,
        input  Vid_Req, Vid_Mode, Vid_Data, Vid_Arg
    );

    modport slave (
        input  IO_Enable, IO_Selection, Draw_Select, Op_A, Op_B,
        input  Switch_Data, Switch_Confirm, Key_Valid, Key_Code, Vid_Ready,
        output Stall, Read_Data, Read_Valid, Key_Ack, Disp_Data, Disp_Load,
        output Vid_Req, Vid_Mode, Vid_Data, Vid_Arg
    );
endinterface

// File: rtl/io_sequencer.sv
// Multi-cycle IO sequencer: OUT retires without stalling; IN/GETCH/DRAW stall until the peripheral
// completes, then spend one DONE cycle retiring. Waits indefinitely on switch, keyboard or video unit.
module io_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int SW_WIDTH   = 16,
    parameter int KEY_WIDTH  = 8
) (
    input logic         Clock,
    input logic         Reset,
    io_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WAIT_SW, WAIT_REL, WAIT_KEY, WAIT_VID, DONE
    } state_t;

    state_t                state_q;
    logic                  op_read_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;
    logic [DATA_WIDTH-1:0] disp_data_q;
    logic                  disp_load_q;
    logic                  vid_req_q;
    logic                  vid_mode_q;
    logic [DATA_WIDTH-1:0] vid_data_q;
    logic [DATA_WIDTH-1:0] vid_arg_q;

    logic [DATA_WIDTH-1:0] sw_ext;
    logic [DATA_WIDTH-1:0] key_ext;
    logic                  stall;

    assign sw_ext  = {{(DATA_WIDTH-SW_WIDTH){1'b0}}, bus.Switch_Data};
    assign key_ext = {{(DATA_WIDTH-KEY_WIDTH){1'b0}}, bus.Key_Code};

    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:                                 stall = bus.IO_Enable && (bus.IO_Selection != 2'd0);
            WAIT_SW, WAIT_REL, WAIT_KEY, WAIT_VID: stall = 1'b1;
            default:                              stall = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            op_read_q    <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_load_q  <= 1'b0;
            vid_req_q    <= 1'b0;
            vid_mode_q   <= 1'b0;
            vid_data_q   <= '0;
            vid_arg_q    <= '0;
        end else begin
            disp_load_q  <= 1'b0;
            read_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.IO_Enable) begin
                        case (bus.IO_Selection)
                            2'd0: begin
                                disp_data_q <= bus.Op_A;
                                disp_load_q <= 1'b1;
                            end
                            2'd1: begin
                                state_q   <= WAIT_SW;
                                op_read_q <= 1'b1;
                            end
                            2'd2: begin
                                state_q   <= WAIT_KEY;
                                op_read_q <= 1'b1;
                            end
                            default: begin
                                state_q    <= WAIT_VID;
                                op_read_q  <= 1'b0;
                                vid_req_q  <= 1'b1;
                                vid_mode_q <= bus.Draw_Select;
                                vid_data_q <= bus.Op_A;
                                vid_arg_q  <= bus.Op_B;
                            end
                        endcase
                    end
                end
                WAIT_SW: begin
                    if (bus.Switch_Confirm) begin
                        read_data_q <= sw_ext;
                        state_q     <= WAIT_REL;
                    end
                end
                // Require release so a single long press cannot satisfy two INs.
                WAIT_REL: begin
                    if (!bus.Switch_Confirm) begin
                        state_q      <= DONE;
                        read_valid_q <= op_read_q;
                    end
                end
                WAIT_KEY: begin
                    if (bus.Key_Valid) begin
                        read_data_q  <= key_ext;
                        state_q      <= DONE;
                        read_valid_q <= op_read_q;
                    end
                end
                WAIT_VID: begin
                    if (bus.Vid_Ready) begin
                        vid_req_q    <= 1'b0;
                        state_q      <= DONE;
                        read_valid_q <= op_read_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Stall      = stall;
    assign bus.Key_Ack    = (state_q == WAIT_KEY) && bus.Key_Valid;
    assign bus.Read_Data  = read_data_q;
    assign bus.Read_Valid = read_valid_q;
    assign bus.Disp_Data  = disp_data_q;
    assign bus.Disp_Load  = disp_load_q;
    assign bus.Vid_Req    = vid_req_q;
    assign bus.Vid_Mode   = vid_mode_q;
    assign bus.Vid_Data   = vid_data_q;
    assign bus.Vid_Arg    = vid_arg_q;
endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer: each IO op is stepped cycle by cycle and its stall, handshake
// and writeback activity is tallied against hand-computed counts.
module tb_io_sequencer;
    logic Clock;
    logic Reset;
    int   n_checks;
    int   n_errors;

    io_sequencer_if bus ();

    io_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int          stalls, acks, ack_cyc, rv_cnt, rv_cyc, vreq, bad, dl_cnt, dl_cyc;
    logic [31:0] rd;

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b1;
        bus.IO_Enable = 1'b0;  bus.IO_Selection = 2'd0; bus.Draw_Select = 1'b0;
        bus.Op_A = '0;         bus.Op_B = '0;
        bus.Switch_Data = '0;  bus.Switch_Confirm = 1'b0;
        bus.Key_Valid = 1'b0;  bus.Key_Code = '0;       bus.Vid_Ready = 1'b0;
        tick(); tick();
        check_eq("rst_stall",     32'(bus.Stall), 0);
        check_eq("rst_read_data", bus.Read_Data, 0);
        check_eq("rst_disp_data", bus.Disp_Data, 0);
        check_eq("rst_vid_req",   32'(bus.Vid_Req), 0);
        check_eq("rst_outs",      {28'd0, bus.Read_Valid, bus.Key_Ack, bus.Disp_Load, bus.Vid_Mode}, 0);
        Reset = 1'b0;
        tick();

        // OUT 0x0000ABCD
        bus.IO_Enable = 1'b1; bus.IO_Selection = 2'd0; bus.Op_A = 32'h0000_ABCD;
        #1;
        check_eq("out_stall", 32'(bus.Stall), 0);
        tick();
        bus.IO_Enable = 1'b0; bus.Op_A = 32'h1111_1111;
        #1;
        check_eq("out_disp_data", bus.Disp_Data, 32'h0000_ABCD);
        check_eq("out_disp_load", 32'(bus.Disp_Load), 1);
        tick();
        check_eq("out_load_once", 32'(bus.Disp_Load), 0);
        check_eq("out_disp_hold", bus.Disp_Data, 32'h0000_ABCD);

        // GETCH with key arriving after 5 empty cycles
        bus.IO_Enable = 1'b1; bus.IO_Selection = 2'd2; bus.Key_Code = 8'h1C;
        stalls = 0; acks = 0; ack_cyc = -1; rv_cnt = 0; rv_cyc = -1; rd = '0;
        for (int c = 0; c < 20; c++) begin
            bus.Key_Valid = (c >= 5);
            #1;
            if (bus.Stall)   stalls++;
            if (bus.Key_Ack) begin acks++; ack_cyc = c; end
            if (bus.Read_Valid) begin rv_cnt++; rv_cyc = c; rd = bus.Read_Data; end
            tick();
            bus.IO_Enable = 1'b0;
        end
        bus.Key_Valid = 1'b0;
        check_eq("getch_stalls",  stalls, 6);
        check_eq("getch_acks",    acks, 1);
        check_eq("getch_ack_cyc", ack_cyc, 5);
        check_eq("getch_rv_cnt",  rv_cnt, 1);
        check_eq("getch_rv_cyc",  rv_cyc, 6);
        check_eq("getch_data",    rd, 32'h0000_001C);

        // IN 0x8001, confirm held 4 cycles
        bus.IO_Enable = 1'b1; bus.IO_Selection = 2'd1; bus.Switch_Data = 16'h8001;
        stalls = 0; rv_cnt = 0; rv_cyc = -1; rd = '0;
        for (int c = 0; c < 20; c++) begin
            bus.Switch_Confirm = (c >= 2 && c <= 5);
            #1;
            if (bus.Stall) stalls++;
            if (bus.Read_Valid) begin rv_cnt++; rv_cyc = c; rd = bus.Read_Data; end
            tick();
            bus.IO_Enable = 1'b0;
        end
        check_eq("in1_stalls", stalls, 7);
        check_eq("in1_rv_cnt", rv_cnt, 1);
        check_eq("in1_rv_cyc", rv_cyc, 7);
        check_eq("in1_data",   rd, 32'h0000_8001);

        // Second IN waits for a fresh press
        bus.IO_Enable = 1'b1; bus.IO_Selection = 2'd1; bus.Switch_Data = 16'h1234;
        stalls = 0; rv_cnt = 0; rv_cyc = -1; rd = '0;
        for (int c = 0; c < 20; c++) begin
            bus.Switch_Confirm = (c == 6);
            #1;
            if (bus.Stall) stalls++;
            if (bus.Read_Valid) begin rv_cnt++; rv_cyc = c; rd = bus.Read_Data; end
            tick();
            bus.IO_Enable = 1'b0;
        end
        bus.Switch_Confirm = 1'b0;
        check_eq("in2_stalls", stalls, 8);
        check_eq("in2_rv_cyc", rv_cyc, 8);
        check_eq("in2_data",   rd, 32'h0000_1234);
        check_eq("read_hold",  bus.Read_Data, 32'h0000_1234);

        // DWCH with Vid_Ready low for 3 request cycles; operands change after issue
        bus.IO_Enable = 1'b1; bus.IO_Selection = 2'd3; bus.Draw_Select = 1'b1;
        bus.Op_A = 32'h0000_0041; bus.Op_B = 32'h0005_0003;
        stalls = 0; vreq = 0; bad = 0; rv_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            bus.Vid_Ready = (c >= 4);
            #1;
            if (bus.Stall) stalls++;
            if (bus.Read_Valid) rv_cnt++;
            if (bus.Vid_Req) begin
                vreq++;
                if (bus.Vid_Mode !== 1'b1 || bus.Vid_Data !== 32'h0000_0041 ||
                    bus.Vid_Arg !== 32'h0005_0003) bad++;
            end
            tick();
            bus.IO_Enable = 1'b0; bus.Draw_Select = 1'b0;
            bus.Op_A = 32'hFFFF_FFFF; bus.Op_B = 32'hEEEE_EEEE;
        end
        bus.Vid_Ready = 1'b0;
        check_eq("draw_vreq",   vreq, 4);
        check_eq("draw_stable", bad, 0);
        check_eq("draw_stalls", stalls, 5);
        check_eq("draw_no_rv",  rv_cnt, 0);
        check_eq("draw_req_off", 32'(bus.Vid_Req), 0);

        // GETCH followed directly by OUT; decoder holds the GETCH until it retires
        bus.Key_Valid = 1'b1; bus.Key_Code = 8'h55;
        stalls = 0; acks = 0; rv_cnt = 0; dl_cnt = 0; dl_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            bus.IO_Enable    = (c <= 3);
            bus.IO_Selection = (c <= 2) ? 2'd2 : 2'd0;
            bus.Op_A         = (c == 3) ? 32'h0000_CAFE : 32'h0BAD_0BAD;
            #1;
            if (bus.Stall) stalls++;
            if (bus.Key_Ack) acks++;
            if (bus.Read_Valid) rv_cnt++;
            if (bus.Disp_Load) begin dl_cnt++; dl_cyc = c; end
            tick();
        end
        bus.Key_Valid = 1'b0;
        check_eq("b2b_acks",   acks, 1);
        check_eq("b2b_stalls", stalls, 2);
        check_eq("b2b_rv",     rv_cnt, 1);
        check_eq("b2b_dl_cnt", dl_cnt, 1);
        check_eq("b2b_dl_cyc", dl_cyc, 4);
        check_eq("b2b_disp",   bus.Disp_Data, 32'h0000_CAFE);
        check_eq("b2b_rdata",  bus.Read_Data, 32'h0000_0055);

        // Reset while waiting on the video unit
        bus.IO_Enable = 1'b1; bus.IO_Selection = 2'd3; bus.Draw_Select = 1'b0;
        bus.Op_A = 32'hDEAD_BEEF; bus.Op_B = 32'h0000_0007; bus.Vid_Ready = 1'b0;
        tick();
        bus.IO_Enable = 1'b0;
        tick(); tick();
        check_eq("mid_vid_req",  32'(bus.Vid_Req), 1);
        check_eq("mid_vid_data", bus.Vid_Data, 32'hDEAD_BEEF);
        Reset = 1'b1;
        #1;
        check_eq("arst_vid_req",  32'(bus.Vid_Req), 0);
        check_eq("arst_stall",    32'(bus.Stall), 0);
        check_eq("arst_vid_data", bus.Vid_Data, 0);
        check_eq("arst_disp",     bus.Disp_Data, 0);
        tick();
        Reset = 1'b0;
        tick();
        check_eq("post_rst_stall", 32'(bus.Stall), 0);
        check_eq("post_rst_req",   32'(bus.Vid_Req), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
